// File: rtl/vga_pattern_sched.sv
// Frame-level test-pattern scheduler for a 640x480 timing generator.
// Picks one of four built-in patterns, advances at vsync rising edges
// (auto timer or manual request) and optionally inserts black frames
// between patterns. Pixel output is combinational from pix_x/pix_y.
module vga_pattern_sched #(
  parameter int unsigned FRAMES_PER_PAT = 60,
  parameter int unsigned BLANK_FRAMES   = 1,
  parameter int unsigned GRID_SHIFT     = 5,
  parameter logic [15:0] SOLID_COLOR    = 16'hFFFF
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic        auto_mode,
  input  logic        next_req,
  input  logic        vsync,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic [1:0]  pat_sel,
  output logic [7:0]  frame_cnt,
  output logic        pat_chg,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_RUN      = 2'd2,
    S_BLANK    = 2'd3
  } state_t;

  localparam logic [7:0] FPP_LAST   = 8'(FRAMES_PER_PAT - 1);
  localparam logic [3:0] BLANK_LAST = 4'((BLANK_FRAMES == 0) ? 0 : BLANK_FRAMES - 1);
  localparam bit         NO_BLANK   = (BLANK_FRAMES == 0);
  localparam logic [9:0] GRID_MASK  = 10'((1 << GRID_SHIFT) - 1);
  localparam logic [9:0] COORD_NONE = 10'h3FF;
  localparam logic [9:0] X_LAST     = 10'd639;
  localparam logic [9:0] Y_LAST     = 10'd479;

  state_t     state;
  logic       vsync_d;
  logic       next_pend;
  logic [3:0] blank_cnt;
  logic       frame_tick;
  logic       sw;

  // Eight 80-pixel color bars, white on the left down to black on the right.
  function automatic logic [15:0] bar_color(input logic [9:0] x);
    logic [15:0] c;
    if      (x < 10'd80)  c = 16'hFFFF;
    else if (x < 10'd160) c = 16'hFFE0;
    else if (x < 10'd240) c = 16'h07FF;
    else if (x < 10'd320) c = 16'h07E0;
    else if (x < 10'd400) c = 16'hF81F;
    else if (x < 10'd480) c = 16'hF800;
    else if (x < 10'd560) c = 16'h001F;
    else                  c = 16'h0000;
    return c;
  endfunction

  // Grid lines every 2**GRID_SHIFT pixels plus a closing line on the far edges.
  function automatic logic [15:0] grid_color(input logic [9:0] x, input logic [9:0] y);
    logic on_line;
    on_line = ((x & GRID_MASK) == 10'd0) || ((y & GRID_MASK) == 10'd0) ||
              (x == X_LAST) || (y == Y_LAST);
    return on_line ? 16'hFFFF : 16'h0000;
  endfunction

  // Reset value 1 keeps a vsync that is already high at release from ticking.
  assign frame_tick = vsync & ~vsync_d;
  // A request landing on the tick itself counts for that tick.
  assign sw = next_pend | next_req | (auto_mode & (frame_cnt >= FPP_LAST));
  assign state_o = state;

  // Delayed vsync for rising-edge detection.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) vsync_d <= 1'b1;
    else         vsync_d <= vsync;
  end

  // Scheduler FSM: pattern selection, frame counting, blank insertion.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      pat_sel   <= 2'd0;
      frame_cnt <= 8'd0;
      pat_chg   <= 1'b0;
      next_pend <= 1'b0;
      blank_cnt <= 4'd0;
    end else begin
      pat_chg <= 1'b0;
      if (!en) begin
        state     <= S_IDLE;
        next_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: state <= S_WAIT_SOF;
          S_WAIT_SOF: begin
            if (frame_tick) begin
              state     <= S_RUN;
              frame_cnt <= 8'd0;
            end
          end
          S_RUN: begin
            if (frame_tick) begin
              if (sw) begin
                next_pend <= 1'b0;
                if (NO_BLANK) begin
                  pat_sel   <= pat_sel + 2'd1;
                  frame_cnt <= 8'd0;
                  pat_chg   <= 1'b1;
                end else begin
                  state     <= S_BLANK;
                  blank_cnt <= 4'd0;
                end
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end else if (next_req) begin
              next_pend <= 1'b1;
            end
          end
          S_BLANK: begin
            if (frame_tick) begin
              if (blank_cnt == BLANK_LAST) begin
                state     <= S_RUN;
                pat_sel   <= pat_sel + 2'd1;
                frame_cnt <= 8'd0;
                pat_chg   <= 1'b1;
              end else begin
                blank_cnt <= blank_cnt + 4'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Pixel generator: black unless running and inside the active area.
  always_comb begin
    pix_data = 16'h0000;
    if (state == S_RUN && pix_x != COORD_NONE && pix_y != COORD_NONE) begin
      case (pat_sel)
        2'd0:    pix_data = bar_color(pix_x);
        2'd1:    pix_data = grid_color(pix_x, pix_y);
        2'd2:    pix_data = {pix_x[9:5], pix_y[8:3], 5'd0};
        default: pix_data = SOLID_COLOR;
      endcase
    end
  end

endmodule
